// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider (start -> A,B sampled; width iterations; done pulses with Q,R,div_zero)
module seq_restoring_divider #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  output logic [width-1:0] Q,
  output logic [width-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int cw = $clog2(width + 1);
  localparam logic [1:0] idle = 2'd0;
  localparam logic [1:0] run  = 2'd1;
  localparam logic [1:0] fin  = 2'd2;
  logic [1:0]       state;
  logic [width:0]   rem, sh_rem, trial;
  logic [width-1:0] quo, dvs;
  logic [cw-1:0]    cnt;
  logic             dz;
  logic             accept, last;
  always_comb begin
    sh_rem = {rem[width-1:0], quo[width-1]};
    trial  = sh_rem - {1'b0, dvs};
    last   = cnt == cw'(width);
    accept = start && (state == idle || state == fin);
    busy   = state == run && !last;
    done   = state == fin;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= idle;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      dz       <= 1'b0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      state <= run;
      rem   <= '0;
      quo   <= A;
      dvs   <= B;
      dz    <= B == '0;
      cnt   <= '0;
    end else if (state == run && last) begin
      state    <= fin;
      Q        <= quo;
      R        <= rem[width-1:0];
      div_zero <= dz;
    end else if (state == run) begin
      rem <= trial[width] ? sh_rem : trial;
      quo <= {quo[width-2:0], ~trial[width]};
      cnt <= cnt + cw'(1);
    end else if (state == fin) begin
      state <= idle;
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench for seq_restoring_divider
module tb_seq_restoring_divider;
  localparam int W = 8;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] A = '0, B = '0, Q, R;
  logic busy, done, div_zero;
  typedef struct {logic [W-1:0] a, b, q, r; logic dz;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, lat, nb, e0;
  logic [W-1:0] ea[4] = '{8'd255, 8'd5, 8'd0, 8'd255};
  logic [W-1:0] eb[4] = '{8'd1, 8'd9, 8'd13, 8'd255};
  seq_restoring_divider #(.width(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done) begin
      chk("busy_with_done", 32'(busy), 0);
      chk("done_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q", 32'(Q), 32'(e.q));
        chk("r", 32'(R), 32'(e.r));
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        if (e.b != 0) chk("q_b_plus_r", 32'(Q) * 32'(e.b) + 32'(R), 32'(e.a));
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.q = b == 0 ? '1 : a / b;
    e.r = b == 0 ? a : a % b;
    e.dz = b == 0;
    sb.push_back(e);
    A = a;
    B = b;
    start = 1;
    step(1);
    start = 0;
  endtask
  task automatic wait_done(output int l, output int n);
    l = 0;
    n = 0;
    while (!done && l < 30) begin
      n += int'(busy);
      step(1);
      l++;
    end
    chk("done_timeout", 32'(done), 1);
  endtask
  initial begin
    step(2);
    chk("rst_q", 32'(Q), 0);
    chk("rst_r", 32'(R), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dz", 32'(div_zero), 0);
    rst = 0;
    step(1);
    issue(200, 7);
    wait_done(lat, nb);
    chk("latency", lat, 9);
    chk("busy_cycles", nb, 8);
    step(1);
    for (int i = 0; i < 4; i++) begin
      issue(ea[i], eb[i]);
      wait_done(lat, nb);
      step(1);
    end
    issue(77, 0);
    wait_done(lat, nb);
    chk("dz_latency", lat, 9);
    step(2);
    chk("dz_hold_idle", 32'(div_zero), 1);
    issue(10, 3);
    chk("dz_hold_busy", 32'(div_zero), 1);
    wait_done(lat, nb);
    step(1);
    issue(100, 9);
    step(3);
    A = 50;
    B = 5;
    start = 1;
    step(1);
    start = 0;
    wait_done(lat, nb);
    step(15);
    chk("dropped_req", sb.size(), 0);
    issue(100, 9);
    wait_done(lat, nb);
    issue(50, 5);
    wait_done(lat, nb);
    chk("b2b_latency", lat, 9);
    step(1);
    issue(200, 3);
    step(3);
    rst = 1;
    sb.delete();
    step(1);
    chk("mid_rst_q", 32'(Q), 0);
    chk("mid_rst_r", 32'(R), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    rst = 0;
    step(15);
    issue(9, 2);
    wait_done(lat, nb);
    step(1);
    e0 = errors;
    for (int i = 0; i < 50; i++) begin
      issue(W'($urandom_range(0, 255)), W'($urandom_range(1, 255)));
      wait_done(lat, nb);
      step(1);
    end
    $display("Random: %0d of 50 operations clean", 50 - ((errors - e0) > 50 ? 50 : errors - e0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
